alu_requester: RTL and testbench

Initiator side of the 8-bit ALU operand/result interface: buffers incoming commands in a small FIFO and drives each one onto the ALU's `op`/`a`/`b` inputs. It holds the operands for a configurable settle time, samples the ALU result, and returns it on a valid/ready response channel. It sits between a command source (sequencer or testbench driver) and a purely combinational four-op ALU (ADD/SUB/MUL/DIV).

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_requester_if.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_requester.sv | 147 ++++++++++++++
 tb/tb_alu_requester.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester: opcodes, data width, command layout and FSM states.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_div_zero(input cmd_t c);
    return (c.op == ALU_DIV) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_requester_if.sv
// Command, ALU-drive and response signals of the requester; master = requester, slave = its environment.
interface alu_requester_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_op;
  logic              rsp_err;

  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_op, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_op, rsp_err, busy
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, head visible combinationally whenever non-empty; push ignored when full.
// Zero-latency read of the head; a push in the same cycle as a pop still cannot exceed DEPTH entries.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/alu_requester.sv
// Buffers commands, drives them to a combinational ALU for SETTLE cycles, returns results in order on rsp_*.
// cmd_ready = FIFO not full; rsp held until rsp_ready. `ALU_REQ_DIVZ_CHK_EN answers DIV-by-zero without issuing.
module alu_requester
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  alu_requester_if.master bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state_q;
  state_t            state_d;
  cmd_t              cmd_in;
  cmd_t              head;
  cmd_t              ops_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              load_ops;
  logic              sample;
  logic              divz;
  logic              short_circuit;
  logic [3:0]        settle_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_op_q;

  assign cmd_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  assign push   = bus.cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef ALU_REQ_DIVZ_CHK_EN
  assign short_circuit = is_div_zero(head);
`else
  assign short_circuit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_ops = 1'b0;
    sample   = 1'b0;
    divz     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      ISSUE: begin
        if (settle_q == SETTLE_LAST) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          if (!fifo_empty) pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop overrides the RESP->IDLE exit so back-to-back commands lose no cycle.
    if (pop) begin
      if (short_circuit) begin
        divz    = 1'b1;
        state_d = RESP;
      end else begin
        load_ops = 1'b1;
        state_d  = ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q      <= '0;
      settle_q   <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
    end else begin
      if (load_ops) ops_q <= head;
      if (pop)                   settle_q <= '0;
      else if (state_q == ISSUE) settle_q <= settle_q + 1'b1;
      if (sample) begin
        rsp_data_q <= bus.alu_out;
        rsp_op_q   <= ops_q.op;
      end else if (divz) begin
        rsp_data_q <= '1;
        rsp_op_q   <= ALU_DIV;
      end
    end
  end

`ifdef ALU_REQ_DIVZ_CHK_EN
  logic rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rsp_err_q <= 1'b0;
    else if (sample) rsp_err_q <= 1'b0;
    else if (divz)   rsp_err_q <= 1'b1;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = !fifo_full;
  assign bus.alu_op    = ops_q.op;
  assign bus.alu_a     = ops_q.a;
  assign bus.alu_b     = ops_q.b;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;

  property p_rsp_hold;
    @(posedge clk) disable iff (rst)
      (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_op));
  endproperty
  a_rsp_hold: assert property (p_rsp_hold);

endmodule

// File: tb/tb_alu_requester.sv
// Scoreboard bench: two requesters (SETTLE=1 with an ideal ALU, SETTLE=3 with a slow-settling ALU).
module tb_alu_requester;
  import alu_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       err;
  } exp_t;

`ifdef ALU_REQ_DIVZ_CHK_EN
  localparam logic [7:0] DZ_DATA  = 8'hFF;
  localparam logic       DZ_ERR   = 1'b1;
  localparam logic       DZ_EARLY = 1'b1;
`else
  localparam logic [7:0] DZ_DATA  = 8'h00;
  localparam logic       DZ_ERR   = 1'b0;
  localparam logic       DZ_EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  alu_requester_if b1();
  alu_requester_if b3();

  alu_requester #(.DEPTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_requester #(.DEPTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return p[7:0];
      default: return (b == 8'd0) ? 8'h00 : a / b;
    endcase
  endfunction

  assign b1.alu_out = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);

  // Slow ALU: shows 8'h5A until the operands have been stable for two edges.
  logic [17:0] prev3 = '0;
  logic [1:0]  age3  = 2'd3;
  always @(posedge clk) begin
    if ({b3.alu_op, b3.alu_a, b3.alu_b} != prev3) begin
      prev3 <= {b3.alu_op, b3.alu_a, b3.alu_b};
      age3  <= 2'd0;
    end else if (age3 != 2'd3) begin
      age3 <= age3 + 2'd1;
    end
  end
  assign b3.alu_out = (age3 >= 2'd1 && {b3.alu_op, b3.alu_a, b3.alu_b} == prev3)
                      ? alu_f(b3.alu_op, b3.alu_a, b3.alu_b) : 8'h5A;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && b1.rsp_valid && b1.rsp_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp1: got op=%0d data=%0h, required no response", b1.rsp_op, b1.rsp_data);
      end else begin
        e = q1.pop_front();
        chk("rsp1", 32'({b1.rsp_op, b1.rsp_data, b1.rsp_err}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && b3.rsp_valid && b3.rsp_ready) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp3: got op=%0d data=%0h, required no response", b3.rsp_op, b3.rsp_data);
      end else begin
        e = q3.pop_front();
        chk("rsp3", 32'({b3.rsp_op, b3.rsp_data, b3.rsp_err}), 32'(e));
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send1(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic err, input bit track);
    int n = 0;
    b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b;
    @(negedge clk);
    while (!b1.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!b1.cmd_ready) begin
      checks++; errors++;
      $display("FAIL send1_timeout: cmd_ready=0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if (track) q1.push_back('{op: op, data: d, err: err});
    b1.cmd_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic err);
    int n = 0;
    b3.cmd_valid = 1'b1; b3.cmd_op = op; b3.cmd_a = a; b3.cmd_b = b;
    @(negedge clk);
    while (!b3.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!b3.cmd_ready) begin
      checks++; errors++;
      $display("FAIL send3_timeout: cmd_ready=0, required 1 within 200 cycles");
    end
    @(posedge clk); #1;
    q3.push_back('{op: op, data: d, err: err});
    b3.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit which);
    int n = 0;
    @(negedge clk);
    while (n < 300 && (which ? (b3.busy || q3.size() != 0) : (b1.busy || q1.size() != 0))) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout%0d: still busy after 300 cycles, required idle", which ? 3 : 1);
    end
    @(posedge clk); #1;
  endtask

  logic [1:0] fop [6] = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_ADD, ALU_SUB};
  logic [7:0] fa  [6] = '{8'd1, 8'd9, 8'd3, 8'd200, 8'd255, 8'd0};
  logic [7:0] fb  [6] = '{8'd2, 8'd4, 8'd5, 8'd9,   8'd2,   8'd1};
  logic [7:0] fex [6] = '{8'h03, 8'h05, 8'h0F, 8'h16, 8'h01, 8'hFF};

  initial begin
    int  acc;
    int  n;
    logic rdy;
    rst = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_op = '0; b1.cmd_a = '0; b1.cmd_b = '0; b1.rsp_ready = 1'b1;
    b3.cmd_valid = 1'b0; b3.cmd_op = '0; b3.cmd_a = '0; b3.cmd_b = '0; b3.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst_busy",      32'(b1.busy),      32'd0);
    chk("rst_cmd_ready", 32'(b1.cmd_ready), 32'd1);
    chk("rst_alu",       32'({b1.alu_op, b1.alu_a, b1.alu_b}), 32'd0);
    chk("rst_rsp",       32'({b1.rsp_op, b1.rsp_data, b1.rsp_err}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ADD 20+22 with exact latency
    send1(ALU_ADD, 8'd20, 8'd22, 8'd42, 1'b0, 1'b1);
    chk("lat_n0_valid", 32'(b1.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_n1_valid", 32'(b1.rsp_valid), 32'd0);
    chk("lat_n1_alu_a", 32'(b1.alu_a), 32'd20);
    chk("lat_n1_busy",  32'(b1.busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(b1.rsp_valid), 32'd1);
    wait_idle(1'b0);

    send1(ALU_MUL, 8'd20, 8'd20, 8'h90, 1'b0, 1'b1);
    send1(ALU_DIV, 8'd100, 8'd7, 8'h0E, 1'b0, 1'b1);
    wait_idle(1'b0);

    // SUB wraps and is held while rsp_ready is low
    b1.rsp_ready = 1'b0;
    send1(ALU_SUB, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(b1.rsp_valid), 32'd1);
      chk("hold_data",  32'(b1.rsp_data),  32'hFE);
    end
    @(posedge clk); #1;
    b1.rsp_ready = 1'b1;
    wait_idle(1'b0);

    // Fill: 6 offered with rsp_ready low, 5 fit
    b1.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      b1.cmd_valid = 1'b1; b1.cmd_op = fop[i]; b1.cmd_a = fa[i]; b1.cmd_b = fb[i];
      @(negedge clk); rdy = b1.cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        q1.push_back('{op: fop[i], data: fex[i], err: 1'b0});
      end
    end
    chk("fill_accepted",  32'(acc), 32'd5);
    chk("fill_cmd_ready", 32'(b1.cmd_ready), 32'd0);
    b1.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b1.cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("fill_reaccept", 32'(b1.cmd_ready), 32'd1);
    @(posedge clk); #1;
    q1.push_back('{op: fop[5], data: fex[5], err: 1'b0});
    b1.cmd_valid = 1'b0;
    wait_idle(1'b0);

    // SETTLE=3 against the slow ALU, back to back
    send3(ALU_ADD, 8'd3, 8'd4, 8'h07, 1'b0);
    send3(ALU_SUB, 8'd50, 8'd8, 8'h2A, 1'b0);
    wait_idle(1'b1);

    // DIV by zero on the SETTLE=3 instance
    send3(ALU_DIV, 8'd9, 8'd0, DZ_DATA, DZ_ERR);
    @(posedge clk); #1;
    chk("divz_early_valid", 32'(b3.rsp_valid), 32'(DZ_EARLY));
    chk("divz_alu_b",       32'(b3.alu_b), DZ_EARLY ? 32'd8 : 32'd0);
    wait_idle(1'b1);

    // Reset while in RESP with two commands queued
    b1.rsp_ready = 1'b0;
    send1(ALU_ADD, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);
    send1(ALU_ADD, 8'd2, 8'd2, 8'd4, 1'b0, 1'b0);
    send1(ALU_ADD, 8'd3, 8'd3, 8'd6, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!b1.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("pre_rst_valid", 32'(b1.rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(b1.rsp_valid), 32'd0);
    chk("mid_rst_busy",  32'(b1.busy),      32'd0);
    chk("mid_rst_ready", 32'(b1.cmd_ready), 32'd1);
    chk("mid_rst_alu",   32'({b1.alu_op, b1.alu_a, b1.alu_b}), 32'd0);
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    b1.rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(b1.busy), 32'd0);

    chk("drain1", 32'(q1.size()), 32'd0);
    chk("drain3", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1);
  end

endmodule
